// File: rtl/rgb_color_selector.sv
// rgb_color_selector: synchronises, debounces and edge-detects three push-buttons and steps a 3-bit colour code.
// Define AUTO_CYCLE_EN to compile in the timed auto-cycle stepping driven by auto_en.
module rgb_color_selector #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned AUTO_PERIOD_MS = 500
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_clear,
  input  logic       auto_en,
  output logic [2:0] color,
  output logic       color_changed,
  output logic       auto_active
);

  localparam int unsigned DB_CYCLES   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned AUTO_CYCLES = CLK_FREQ / 1000 * AUTO_PERIOD_MS;
  localparam int unsigned DB_W        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned AUTO_W      = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam int unsigned NBTN        = 3;
  localparam int unsigned B_NEXT      = 0;
  localparam int unsigned B_PREV      = 1;
  localparam int unsigned B_CLEAR     = 2;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] stable_q, stable_d;
  logic [NBTN-1:0] stable_dly_q;
  logic [NBTN-1:0] press_q, press_d;
  logic [DB_W-1:0] cnt_q [NBTN];
  logic [DB_W-1:0] cnt_d [NBTN];

  logic [2:0] color_q, color_d;
  logic       changed_q, changed_d;
  logic       any_press;
  logic       auto_step;

  assign btn_raw = {btn_clear, btn_prev, btn_next};

  // Per-button debounce: stable follows the synchronised input only after DB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press_d = stable_q & ~stable_dly_q;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign any_press = |press_q;

`ifdef AUTO_CYCLE_EN
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

  logic              auto_active_q;
  logic [AUTO_W-1:0] timer_q, timer_d;

  // Period timer restarts on any press, so a manual step always begins a fresh period.
  always_comb begin
    timer_d   = '0;
    auto_step = 1'b0;
    if (auto_active_q && !any_press) begin
      if (timer_q == AUTO_LAST) begin
        auto_step = 1'b1;
      end else begin
        timer_d = timer_q + AUTO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      auto_active_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      auto_active_q <= auto_en;
      timer_q       <= timer_d;
    end
  end

  assign auto_active = auto_active_q;
`else
  logic unused_auto_en;

  assign unused_auto_en = auto_en;
  assign auto_step      = 1'b0;
  assign auto_active    = 1'b0;
`endif

  // Colour update: clear beats everything, simultaneous next+prev cancel, auto step only when no button acts.
  always_comb begin
    color_d = color_q;
    if (press_q[B_CLEAR]) begin
      color_d = 3'd0;
    end else if (press_q[B_NEXT] && press_q[B_PREV]) begin
      color_d = color_q;
    end else if (press_q[B_NEXT]) begin
      color_d = color_q + 3'd1;
    end else if (press_q[B_PREV]) begin
      color_d = color_q - 3'd1;
    end else if (auto_step) begin
      color_d = color_q + 3'd1;
    end
    changed_d = (color_d != color_q);
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      color_q   <= 3'd0;
      changed_q <= 1'b0;
    end else begin
      color_q   <= color_d;
      changed_q <= changed_d;
    end
  end

  assign color         = color_q;
  assign color_changed = changed_q;

endmodule

// File: tb/tb_rgb_color_selector.sv
// Self-checking bench for rgb_color_selector: directed and random button activity against a colour model.
module tb_rgb_color_selector;

  localparam int unsigned DB   = 4;
  localparam int unsigned LAT  = DB + 3;
  localparam int unsigned AUTO = 10;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       btn_next, btn_prev, btn_clear, auto_en;
  logic [2:0] color;
  logic       color_changed, auto_active;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          model_color = 0;

  rgb_color_selector #(
    .CLK_FREQ      (1000),
    .DEBOUNCE_MS   (4),
    .AUTO_PERIOD_MS(10)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .btn_clear    (btn_clear),
    .auto_en      (auto_en),
    .color        (color),
    .color_changed(color_changed),
    .auto_active  (auto_active)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Expected colour after one set of simultaneous presses, mask = {clear,prev,next}.
  function automatic int predict(input int old, input logic [2:0] mask);
    if (mask[2])                return 0;
    else if (mask[1] && mask[0]) return old;
    else if (mask[0])            return (old + 1) % 8;
    else if (mask[1])            return (old + 7) % 8;
    return old;
  endfunction

  // Hold mask for 'hold' edges, release, then watch colour and pulse cycle by cycle.
  task automatic watch(input string tag, input logic [2:0] mask, input int hold);
    int  old  = model_color;
    bit  regs = (hold >= int'(DB));
    int  nxt  = regs ? predict(old, mask) : old;
    {btn_clear, btn_prev, btn_next} = mask;
    for (int k = 1; k <= hold + int'(DB) + 8; k++) begin
      tick();
      if (k < int'(LAT) + 1) begin
        check({tag, "_color_pre"}, 32'(color), 32'(old));
        check({tag, "_pulse_pre"}, 32'(color_changed), 0);
      end else if (k == int'(LAT) + 1) begin
        check({tag, "_color_new"}, 32'(color), 32'(nxt));
        check({tag, "_pulse_new"}, 32'(color_changed), 32'(nxt != old));
      end else begin
        check({tag, "_color_hold"}, 32'(color), 32'(nxt));
        check({tag, "_pulse_hold"}, 32'(color_changed), 0);
      end
      if (k == hold) {btn_clear, btn_prev, btn_next} = 3'b000;
    end
    model_color = nxt;
  endtask

  initial begin
    reset = 1'b0; auto_en = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_clear = 1'b0;

    // Reset with arbitrary button activity.
    for (int i = 0; i < 3; i++) begin
      {btn_clear, btn_prev, btn_next} = 3'($urandom_range(0, 7));
      auto_en = 1'($urandom_range(0, 1));
      tick();
      check("rst_color", 32'(color), 0);
      check("rst_pulse", 32'(color_changed), 0);
      check("rst_auto", 32'(auto_active), 0);
    end
    {btn_clear, btn_prev, btn_next} = 3'b000;
    auto_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < int'(DB) + 4; i++) tick();
    model_color = 0;

    // Directed steps.
    watch("next_first", 3'b001, 20);
    watch("glitch", 3'b001, 3);
    for (int i = 0; i < 7; i++) watch("next_wrap", 3'b001, 6);
    check("wrap_zero", 32'(color), 0);
    watch("prev_wrap", 3'b010, 6);
    check("prev_seven", 32'(color), 7);
    watch("next_prev", 3'b011, 8);
    watch("prev_a", 3'b010, 5);
    watch("prev_b", 3'b010, 4);
    check("at_five", 32'(color), 5);
    watch("clear_next", 3'b101, 7);
    watch("clear_zero", 3'b100, 7);

    // Random presses and glitches.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] m;
      int         h;
      m = 3'($urandom_range(1, 7));
      h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DB - 1)) : int'($urandom_range(DB, 20));
      watch("rand", m, h);
    end

`ifdef AUTO_CYCLE_EN
    begin
      int anchor;
      bit ev;
      int press_k;
      watch("auto_clr", 3'b100, 6);
      watch("auto_n1", 3'b001, 6);
      watch("auto_n2", 3'b001, 6);
      check("auto_start", 32'(color), 2);
      auto_en = 1'b1;
      anchor  = 1;
      press_k = 26 + int'(LAT);
      for (int k = 1; k <= 85; k++) begin
        tick();
        ev = 1'b0;
        if (k == press_k) begin
          ev = 1'b1; anchor = k;
        end else if (k <= 55 && k - anchor == int'(AUTO)) begin
          ev = 1'b1; anchor = k;
        end
        if (ev) model_color = (model_color + 1) % 8;
        check("auto_active", 32'(auto_active), 32'(k <= 55));
        check("auto_color", 32'(color), 32'(model_color));
        check("auto_pulse", 32'(color_changed), 32'(ev));
        if (k == 25) btn_next = 1'b1;
        if (k == 33) btn_next = 1'b0;
        if (k == 55) auto_en = 1'b0;
      end
      for (int i = 0; i < int'(DB) + 4; i++) tick();
    end
`else
    auto_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("noauto_active", 32'(auto_active), 0);
      check("noauto_color", 32'(color), 32'(model_color));
      check("noauto_pulse", 32'(color_changed), 0);
    end
    auto_en = 1'b0;
`endif

    // Reset mid-press, then a button held through reset release.
    watch("pre_rst", 3'b001, 5);
    btn_next = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("midrst_color", 32'(color), 0);
    check("midrst_pulse", 32'(color_changed), 0);
    check("midrst_auto", 32'(auto_active), 0);
    tick();
    check("midrst_color2", 32'(color), 0);
    reset = 1'b1;
    model_color = 0;
    watch("held_rst", 3'b001, 12);
    check("held_rst_one", 32'(color), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
